// File: rtl/gpu_mem_arbiter.sv
// Two-client memory arbiter: a GPU core (A) and display scanout (B) share one
// memory port. Each client has a single request slot; one memory operation
// is in flight at a time. Reads wait for returned data with a timeout.
module gpu_mem_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         i_rst,
    // GPU core client
    input  logic         i_a_command,
    input  logic         i_a_write,
    input  logic [1:0]   i_a_commandSize,
    input  logic [14:0]  i_a_adr,
    input  logic [2:0]   i_a_subadr,
    input  logic [15:0]  i_a_writeMask,
    input  logic [255:0] i_a_dataOut,
    output logic         o_a_busy,
    output logic         o_a_dataInValid,
    // display scanout client (32-byte reads only)
    input  logic         i_b_command,
    input  logic [14:0]  i_b_adr,
    input  logic         i_b_urgent,
    output logic         o_b_busy,
    output logic         o_b_dataInValid,
    // shared read data
    output logic [255:0] o_dataIn,
    // memory side
    output logic         o_command,
    output logic         o_write,
    output logic [1:0]   o_commandSize,
    output logic [14:0]  o_adr,
    output logic [2:0]   o_subadr,
    output logic [15:0]  o_writeMask,
    output logic [255:0] o_dataOut,
    input  logic         i_busy,
    input  logic         i_dataInValid,
    input  logic [255:0] i_dataIn,
    output logic         o_err_timeout
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    state_t         state;
    logic           a_full, b_full;
    logic           a_write;
    logic [1:0]     a_size;
    logic [14:0]    a_adr;
    logic [2:0]     a_subadr;
    logic [15:0]    a_mask;
    logic [255:0]   a_data;
    logic [14:0]    b_adr;
    logic           last_b;   // last client granted was B
    logic           owner_b;  // client owning the current operation is B
    logic [CW-1:0]  cnt;

    logic pick_b, accept, data_done, timeout, release_op;

    // B wins when urgent, when it is the only one pending, or on a tie when A went last
    assign pick_b     = b_full && (i_b_urgent || !a_full || !last_b);
    assign accept     = (state == ISSUE) && !i_busy;
    assign data_done  = (state == WAIT_DATA) && i_dataInValid;
    assign timeout    = (state == WAIT_DATA) && !i_dataInValid && (cnt == CW'(TIMEOUT_CYC - 1));
    assign release_op = (accept && o_write) || data_done || timeout;

    assign o_a_busy        = a_full;
    assign o_b_busy        = b_full;
    assign o_a_dataInValid = data_done && !owner_b;
    assign o_b_dataInValid = data_done && owner_b;
    assign o_dataIn        = i_rst ? '0 : i_dataIn;

    // A request slot: load on a pulse when empty, free when its operation ends
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            a_full   <= 1'b0;
            a_write  <= 1'b0;
            a_size   <= '0;
            a_adr    <= '0;
            a_subadr <= '0;
            a_mask   <= '0;
            a_data   <= '0;
        end else if (!a_full && i_a_command) begin
            a_full   <= 1'b1;
            a_write  <= i_a_write;
            a_size   <= i_a_commandSize;
            a_adr    <= i_a_adr;
            a_subadr <= i_a_subadr;
            a_mask   <= i_a_writeMask;
            a_data   <= i_a_dataOut;
        end else if (release_op && !owner_b) begin
            a_full   <= 1'b0;
        end
    end

    // B request slot: only the block address needs storing
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            b_full <= 1'b0;
            b_adr  <= '0;
        end else if (!b_full && i_b_command) begin
            b_full <= 1'b1;
            b_adr  <= i_b_adr;
        end else if (release_op && owner_b) begin
            b_full <= 1'b0;
        end
    end

    // Arbitration FSM with registered memory-side outputs
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            o_command     <= 1'b0;
            o_write       <= 1'b0;
            o_commandSize <= '0;
            o_adr         <= '0;
            o_subadr      <= '0;
            o_writeMask   <= '0;
            o_dataOut     <= '0;
            owner_b       <= 1'b0;
            last_b        <= 1'b1;
            cnt           <= '0;
            o_err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_full || b_full) begin
                        state     <= ISSUE;
                        o_command <= 1'b1;
                        owner_b   <= pick_b;
                        last_b    <= pick_b;
                        if (pick_b) begin
                            o_write       <= 1'b0;
                            o_commandSize <= 2'd1;
                            o_adr         <= b_adr;
                            o_subadr      <= '0;
                            o_writeMask   <= '0;
                            o_dataOut     <= '0;
                        end else begin
                            o_write       <= a_write;
                            o_commandSize <= a_size;
                            o_adr         <= a_adr;
                            o_subadr      <= a_subadr;
                            o_writeMask   <= a_mask;
                            o_dataOut     <= a_data;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        o_command <= 1'b0;
                        cnt       <= '0;
                        state     <= o_write ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (i_dataInValid) begin
                        state <= IDLE;
                    end else if (timeout) begin
                        o_err_timeout <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Bench for gpu_mem_arbiter: directed scenarios plus randomized two-client
// episodes checked against a transaction-level arbitration model.
module tb_gpu_mem_arbiter;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_a_command, i_a_write;
    logic [1:0]   i_a_commandSize;
    logic [14:0]  i_a_adr;
    logic [2:0]   i_a_subadr;
    logic [15:0]  i_a_writeMask;
    logic [255:0] i_a_dataOut;
    logic         o_a_busy, o_a_dataInValid;
    logic         i_b_command;
    logic [14:0]  i_b_adr;
    logic         i_b_urgent;
    logic         o_b_busy, o_b_dataInValid;
    logic [255:0] o_dataIn;
    logic         o_command, o_write;
    logic [1:0]   o_commandSize;
    logic [14:0]  o_adr;
    logic [2:0]   o_subadr;
    logic [15:0]  o_writeMask;
    logic [255:0] o_dataOut;
    logic         i_busy, i_dataInValid;
    logic [255:0] i_dataIn;
    logic         o_err_timeout;

    int checks = 0;
    int failures = 0;

    // model state: pending A request fields, B address, last-served client
    bit           m_last_b;
    bit           m_aw;
    logic [1:0]   m_asz;
    logic [14:0]  m_aadr, m_badr;
    logic [2:0]   m_asub;
    logic [15:0]  m_amask;
    logic [255:0] m_adata;

    gpu_mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_a_command(i_a_command), .i_a_write(i_a_write), .i_a_commandSize(i_a_commandSize),
        .i_a_adr(i_a_adr), .i_a_subadr(i_a_subadr), .i_a_writeMask(i_a_writeMask),
        .i_a_dataOut(i_a_dataOut), .o_a_busy(o_a_busy), .o_a_dataInValid(o_a_dataInValid),
        .i_b_command(i_b_command), .i_b_adr(i_b_adr), .i_b_urgent(i_b_urgent),
        .o_b_busy(o_b_busy), .o_b_dataInValid(o_b_dataInValid), .o_dataIn(o_dataIn),
        .o_command(o_command), .o_write(o_write), .o_commandSize(o_commandSize),
        .o_adr(o_adr), .o_subadr(o_subadr), .o_writeMask(o_writeMask), .o_dataOut(o_dataOut),
        .i_busy(i_busy), .i_dataInValid(i_dataInValid), .i_dataIn(i_dataIn),
        .o_err_timeout(o_err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // expected memory-side fields for a grant to client cl (1 = B)
    task automatic chk_fields(input bit cl, input string tag);
        chk({tag, "_write"}, o_write,       cl ? 1'b0  : m_aw);
        chk({tag, "_size"},  o_commandSize, cl ? 2'd1  : m_asz);
        chk({tag, "_adr"},   o_adr,         cl ? m_badr : m_aadr);
        chk({tag, "_sub"},   o_subadr,      cl ? 3'd0  : m_asub);
        chk({tag, "_mask"},  o_writeMask,   cl ? 16'd0 : m_amask);
        chk({tag, "_data"},  o_dataOut,     cl ? 256'd0 : m_adata);
    endtask

    // wait for a command, hold it off for 'stall' edges, then accept it
    task automatic issue_accept(input bit cl, input int stall);
        int n = 0;
        while (o_command !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_seen", o_command, 1'b1);
        chk_fields(cl, "grant");
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("stall_cmd", o_command, 1'b1);
            chk("stall_adr", o_adr, cl ? m_badr : m_aadr);
        end
        i_busy = 1'b0;
        @(negedge clk);
        i_busy = 1'b1;
        chk("cmd_dropped", o_command, 1'b0);
    endtask

    // complete one operation for client cl, including read data return
    task automatic serve(input bit cl, input int stall);
        bit is_write;
        logic [255:0] d;
        int lat;
        is_write = !cl && m_aw;
        issue_accept(cl, stall);
        if (!is_write) begin
            lat = $urandom_range(0, 5);
            for (int k = 0; k < lat; k++) begin
                chk("wait_strobe", {o_a_dataInValid, o_b_dataInValid}, 2'b00);
                @(negedge clk);
            end
            d = rnd256();
            i_dataInValid = 1'b1;
            i_dataIn = d;
            #1;
            chk("strobe_a", o_a_dataInValid, !cl);
            chk("strobe_b", o_b_dataInValid, cl);
            chk("rdata", o_dataIn, d);
            @(negedge clk);
            i_dataInValid = 1'b0;
        end
        chk(cl ? "b_freed" : "a_freed", cl ? o_b_busy : o_a_busy, 1'b0);
        chk("no_err", o_err_timeout, 1'b0);
        m_last_b = cl;
    endtask

    // wmode: 0 read, 1 write, 2 random
    task automatic episode(input bit pa, input bit pb, input bit urg, input int wmode, input int stall);
        bit first;
        m_aw    = (wmode == 2) ? bit'($urandom_range(0, 1)) : bit'(wmode);
        m_asz   = 2'($urandom);
        m_aadr  = 15'($urandom);
        m_asub  = 3'($urandom);
        m_amask = 16'($urandom);
        m_adata = rnd256();
        m_badr  = 15'($urandom);
        if (pa && pb) first = urg ? 1'b1 : !m_last_b;
        else          first = pb;
        @(negedge clk);
        i_a_command = pa; i_a_write = m_aw; i_a_commandSize = m_asz; i_a_adr = m_aadr;
        i_a_subadr = m_asub; i_a_writeMask = m_amask; i_a_dataOut = m_adata;
        i_b_command = pb; i_b_adr = m_badr; i_b_urgent = urg;
        @(negedge clk);
        i_a_command = 1'b0; i_b_command = 1'b0;
        chk("load_a", o_a_busy, pa);
        chk("load_b", o_b_busy, pb);
        serve(first, stall);
        if (pa && pb) serve(!first, $urandom_range(0, 2));
        i_b_urgent = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_a_command = 0; i_a_write = 0; i_a_commandSize = 0; i_a_adr = 0; i_a_subadr = 0;
        i_a_writeMask = 0; i_a_dataOut = 0; i_b_command = 0; i_b_adr = 0; i_b_urgent = 0;
        i_busy = 1; i_dataInValid = 0; i_dataIn = rnd256();
        m_last_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_outs", {o_command, o_a_busy, o_b_busy, o_a_dataInValid, o_b_dataInValid, o_err_timeout}, 6'd0);
        chk("rst_buses", {o_write, o_commandSize, o_adr, o_subadr, o_writeMask}, 37'd0);
        chk("rst_dout", o_dataOut, 256'd0);
        chk("rst_din", o_dataIn, 256'd0);
        i_rst = 1'b0;
        i_dataIn = '0;

        // simultaneous reads after reset: A first, then B
        episode(1, 1, 0, 0, 0);

        // A write with memory never busy: command two cycles after the pulse
        @(negedge clk);
        i_busy = 1'b0;
        m_aw = 1; m_asz = 2'd2; m_aadr = 15'h1234; m_asub = 3'd5; m_amask = 16'hFFFF; m_adata = rnd256();
        i_a_command = 1; i_a_write = 1; i_a_commandSize = m_asz; i_a_adr = m_aadr;
        i_a_subadr = m_asub; i_a_writeMask = m_amask; i_a_dataOut = m_adata;
        @(negedge clk);
        i_a_command = 0;
        chk("w_busy", o_a_busy, 1'b1);
        chk("w_cmd_c1", o_command, 1'b0);
        @(negedge clk);
        chk("w_cmd_c2", o_command, 1'b1);
        chk_fields(1'b0, "w");
        @(negedge clk);
        chk("w_cmd_c3", o_command, 1'b0);
        chk("w_freed", o_a_busy, 1'b0);
        i_busy = 1'b1;
        m_last_b = 1'b0;

        // B alone, then urgent tie goes to B even though B went last
        episode(0, 1, 0, 0, 0);
        episode(1, 1, 1, 2, 0);

        // memory busy for 5 cycles during ISSUE
        episode(1, 0, 0, 1, 5);

        // randomized episodes
        for (int e = 0; e < 30; e++) begin
            int pa, pb;
            pa = $urandom_range(0, 1);
            pb = (pa == 0) ? 1 : $urandom_range(0, 1);
            episode(bit'(pa), bit'(pb), bit'($urandom_range(0, 1)), 2, $urandom_range(0, 3));
        end

        // read timeout after 16 WAIT_DATA cycles
        @(negedge clk);
        m_aw = 0; m_asz = 2'd1; m_aadr = 15'h0ABC; m_asub = 3'd0; m_amask = 16'd0; m_adata = '0;
        i_a_command = 1; i_a_write = 0; i_a_commandSize = m_asz; i_a_adr = m_aadr;
        i_a_subadr = m_asub; i_a_writeMask = m_amask; i_a_dataOut = m_adata;
        @(negedge clk);
        i_a_command = 0;
        issue_accept(1'b0, 0);
        for (int k = 0; k < 16; k++) begin
            chk("to_pending", {o_err_timeout, o_a_busy, o_a_dataInValid}, 3'b010);
            @(negedge clk);
        end
        chk("to_err", o_err_timeout, 1'b1);
        chk("to_freed", o_a_busy, 1'b0);
        chk("to_nostrobe", o_a_dataInValid, 1'b0);
        @(negedge clk);
        chk("to_sticky", o_err_timeout, 1'b1);

        // reset while waiting for read data; late data must be ignored
        m_aadr = 15'h0555;
        i_a_command = 1; i_a_adr = m_aadr;
        @(negedge clk);
        i_a_command = 0;
        issue_accept(1'b0, 0);
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        #1;
        chk("rr_outs", {o_command, o_a_busy, o_b_busy, o_err_timeout}, 4'd0);
        @(negedge clk);
        i_rst = 1'b0;
        i_dataInValid = 1'b1;
        i_dataIn = rnd256();
        #1;
        chk("rr_strobes", {o_a_dataInValid, o_b_dataInValid}, 2'b00);
        @(negedge clk);
        i_dataInValid = 1'b0;
        chk("rr_busy", {o_a_busy, o_b_busy, o_command}, 3'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gpu_mem_arbiter.md
GPU_MEM_ARBITER -- requirements
Module: gpu_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1023, giving the maximum cycles in WAIT_DATA before an abort.
REQ-002 SHALL have port clk, input, 1: single clock; all logic rises on it.
REQ-003 SHALL have port i_rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port i_a_command, input, 1: GPU-core request pulse, legal only while o_a_busy=0.
REQ-005 SHALL have ports i_a_write (1), i_a_commandSize (2), i_a_adr (15), i_a_subadr (3), i_a_writeMask (16), i_a_dataOut (256), all inputs: GPU-core request fields, sampled with i_a_command.
REQ-006 SHALL have port o_a_busy, output, 1: GPU-core slot occupied.
REQ-007 SHALL have port o_a_dataInValid, output, 1: read data for the GPU core is valid this cycle.
REQ-008 SHALL have port i_b_command, input, 1: display-scanout read request pulse; always a 32-byte read.
REQ-009 SHALL have port i_b_adr, input, 15: display-scanout block address.
REQ-010 SHALL have port i_b_urgent, input, 1: scanout FIFO low; B wins arbitration.
REQ-011 SHALL have ports o_b_busy (1) and o_b_dataInValid (1), outputs: same meaning as the A equivalents.
REQ-012 SHALL have port o_dataIn, output, 256: shared read data, passed through from i_dataIn.
REQ-013 SHALL have memory-side ports o_command (1), o_write (1), o_commandSize (2), o_adr (15), o_subadr (3), o_writeMask (16), o_dataOut (256), all outputs; i_busy, input, 1; i_dataInValid, input, 1; i_dataIn, input, 256.
REQ-014 SHALL have port o_err_timeout, output, 1: sticky read-timeout flag.

Function
REQ-015 SHALL hold one request slot per client; an i_x_command pulse while o_x_busy=0 loads the slot, and o_x_busy is high from the next cycle.
REQ-016 SHALL ignore i_x_command while o_x_busy=1, leaving the slot unchanged.
REQ-017 SHALL implement the states IDLE, ISSUE and WAIT_DATA.
REQ-018 SHALL, in IDLE with at least one slot full, select a winner and enter ISSUE on the next edge.
REQ-019 SHALL select the winner as follows, in order:
- B, if i_b_urgent=1 and B is pending;
- otherwise the only pending client;
- otherwise, when both are pending, the client not served last; the last-served register resets to B, so A wins the first tie.
REQ-020 SHALL register the winner's fields onto the memory outputs and assert o_command=1 only in ISSUE; the fields stay stable until acceptance.
REQ-021 SHALL treat a request as accepted on an edge where o_command=1 and i_busy=0.
REQ-022 SHALL, when a write is accepted, clear the owner slot and go to IDLE, so o_x_busy falls the cycle after acceptance.
REQ-023 SHALL, when a read is accepted, go to WAIT_DATA with the owner recorded.
REQ-024 SHALL drive B requests as o_write=0, o_commandSize=1, o_subadr=0 and o_writeMask=0.
REQ-025 SHALL, in WAIT_DATA, assert o_x_dataInValid for the recorded owner combinationally in the same cycle as i_dataInValid=1; the other client's strobe stays 0.
REQ-026 SHALL, on that cycle, clear the owner slot and return to IDLE.
REQ-027 SHALL ignore i_dataInValid in IDLE and ISSUE; no strobe is generated.
REQ-028 SHALL count cycles in WAIT_DATA with a counter that clears on entry.
REQ-029 SHALL, when the counter reaches TIMEOUT_CYC, set o_err_timeout, clear the owner slot and go to IDLE without any strobe.
REQ-030 SHALL deliver the minimum latency of i_x_command pulse to o_command=1 as 2 cycles.
REQ-031 SHALL allow at most one outstanding memory operation at any time.
REQ-032 SHALL accept a new pulse into a slot while the other client's operation is in flight.
REQ-033 SHALL accept a new pulse into a slot the cycle after that slot's o_x_busy falls.

Reset
REQ-034 SHALL, while i_rst=1, immediately force state=IDLE, both slots empty, last-served=B, counter=0 and o_err_timeout=0.
REQ-035 SHALL, while i_rst=1, force all outputs to 0 (o_command, o_x_busy, o_x_dataInValid, o_err_timeout and all address, data and mask buses).
REQ-036 SHALL, on reset mid-operation, abandon the in-flight request; a late i_dataInValid after reset is ignored per REQ-027.

Verification
REQ-037 SHALL be verified with this scenario: A write, adr=0x1234, mask=0xFFFF, i_busy=0 -> o_command=1 two cycles after the pulse with o_adr=0x1234, o_write=1; o_a_busy back at 0 one cycle after acceptance.
REQ-038 SHALL be verified with this scenario: A read and B read pulsed in the same cycle, urgent=0, after reset -> A issued first, then B; each strobe pulses only for its own client.
REQ-039 SHALL be verified with this scenario: A and B pending with i_b_urgent=1 -> B issued first, even when B was served last.
REQ-040 SHALL be verified with this scenario: i_busy held 1 for 5 cycles during ISSUE -> o_command and the fields stay stable for all 5 cycles; acceptance on the 6th edge.
REQ-041 SHALL be verified with this scenario: A read accepted with no i_dataInValid and TIMEOUT_CYC=16 -> after 16 WAIT_DATA cycles o_err_timeout=1, o_a_busy=0, o_a_dataInValid never asserted.
REQ-042 SHALL be verified with this scenario: i_rst pulsed in WAIT_DATA, then i_dataInValid=1 -> all busy flags are 0 and no strobe is generated.
